// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared constants and buffer-occupancy type for the fetch stage
package fetch_unit_pkg;
   localparam int DEF_ADDR_W = 12;
   localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = '0;
   localparam logic [31:0] NOP_INSN = 32'h0;
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_e;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem, decode and redirect signals between fetch and its neighbours
interface fetch_unit_if #(parameter int ADDR_W = fetch_unit_pkg::DEF_ADDR_W);
   logic fetch_en;
   logic [ADDR_W-1:0] address_imem;
   logic [31:0] q_imem;
   logic [31:0] insn_d;
   logic [ADDR_W-1:0] pc_d;
   logic insn_valid;
   logic decode_ready;
   logic redirect;
   logic [ADDR_W-1:0] redirect_pc;
   modport master (
      input fetch_en, q_imem, decode_ready, redirect, redirect_pc,
      output address_imem, insn_d, pc_d, insn_valid
   );
   modport slave (
      output fetch_en, q_imem, decode_ready, redirect, redirect_pc,
      input address_imem, insn_d, pc_d, insn_valid
   );
endinterface

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: 2-entry FIFO with registered head output and flush
module fetch_skid_buffer
   import fetch_unit_pkg::*;
#(
   parameter int WIDTH = 32 + DEF_ADDR_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output occ_e             count
);
   logic [WIDTH-1:0] tail;
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         count <= EMPTY;
         dout  <= '0;
         tail  <= '0;
      end else if (flush) begin
         count <= EMPTY;
      end else begin
         dout  <= (push && (count == EMPTY || (count == ONE && pop))) ? din :
                  (pop && count == TWO) ? tail : dout;
         tail  <= (push && ((count == ONE && !pop) || count == TWO)) ? din : tail;
         count <= occ_e'(2'(count) + 2'(push) - 2'(pop));
      end
   a_no_overflow: assert property (@(posedge clock) disable iff (reset)
      !(push && !pop && !flush && count == TWO));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, imem read issue and skid-buffered handoff to decode
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
   input logic          clock,
   input logic          reset,
   fetch_unit_if.master bus
);
   logic [ADDR_W-1:0] pc, req_pc;
   logic [31+ADDR_W:0] head;
   logic req_valid, pop, push, issue;
   logic [2:0] pending;
   occ_e count;
   assign bus.insn_valid   = count != EMPTY;
   assign pop              = bus.insn_valid & bus.decode_ready;
   // Reserve a buffer slot for every read in flight so a return is never dropped
   assign pending          = 3'(count) + 3'(req_valid) - 3'(pop);
   assign issue            = bus.fetch_en & ~bus.redirect & (pending < 3'd2);
   assign push             = req_valid & ~bus.redirect;
   assign bus.address_imem = pc;
   assign bus.insn_d       = bus.insn_valid ? head[ADDR_W +: 32] : NOP_INSN;
   assign bus.pc_d         = bus.insn_valid ? head[ADDR_W-1:0] : '0;
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         pc        <= RESET_PC;
         req_pc    <= RESET_PC;
         req_valid <= 1'b0;
      end else if (bus.redirect) begin
         pc        <= bus.redirect_pc;
         req_valid <= 1'b0;
      end else begin
         pc        <= issue ? pc + 1'b1 : pc;
         req_pc    <= issue ? pc : req_pc;
         req_valid <= issue;
      end
   fetch_skid_buffer #(.WIDTH(32 + ADDR_W)) u_buf (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop & ~bus.redirect),
      .flush (bus.redirect),
      .din   ({bus.q_imem, req_pc}),
      .dout  (head),
      .count (count)
   );
   a_nop_when_empty: assert property (@(posedge clock) disable iff (reset)
      !bus.insn_valid |-> bus.insn_d == NOP_INSN);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with an in-order delivery model checked every cycle
module tb_fetch_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int vectors = 0;
   int miscompares = 0;
   logic [11:0] exp_pc = 12'h000;
   fetch_unit_if bus ();
   fetch_unit dut (.clock(clk), .reset(rst), .bus(bus));
   always #5 clk = ~clk;
   // imem holds k+100 at word k, one-cycle read latency
   always @(posedge clk) bus.q_imem <= 32'(bus.address_imem) + 32'd100;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic expect_out(input string name, input logic v, input logic [11:0] pc, input logic [31:0] insn);
      check({name, ".valid"}, 32'(bus.insn_valid), 32'(v));
      check({name, ".pc_d"}, 32'(bus.pc_d), 32'(pc));
      check({name, ".insn_d"}, bus.insn_d, insn);
   endtask
   task automatic check_addr(input string name, input logic [11:0] a);
      check({name, ".addr"}, 32'(bus.address_imem), 32'(a));
   endtask
   // Delivered stream must be contiguous from the last reset/redirect target with insn = imem[pc]
   always @(negedge clk) begin
      if (rst) begin
         exp_pc = 12'h000;
         check("rst_valid", 32'(bus.insn_valid), 32'd0);
         check("rst_insn", bus.insn_d, 32'd0);
      end else begin
         if (!bus.insn_valid) begin
            check("idle_insn", bus.insn_d, 32'd0);
            check("idle_pc", 32'(bus.pc_d), 32'd0);
         end else begin
            check("head_pc", 32'(bus.pc_d), 32'(exp_pc));
            check("head_insn", bus.insn_d, 32'(exp_pc) + 32'd100);
         end
         if (bus.redirect) exp_pc = bus.redirect_pc;
         else if (bus.insn_valid && bus.decode_ready) exp_pc = exp_pc + 12'd1;
      end
   end
   initial begin
      logic [15:0] pat;
      pat = 16'b1011_0010_1110_0101;
      bus.fetch_en = 1'b0;
      bus.decode_ready = 1'b0;
      bus.redirect = 1'b0;
      bus.redirect_pc = 12'h000;
      tick(2);
      check_addr("reset", 12'h000);
      expect_out("reset", 1'b0, 12'h000, 32'h0);
      rst = 1'b0;
      bus.fetch_en = 1'b1;
      bus.decode_ready = 1'b1;
      check_addr("t1_c0", 12'h000);
      tick(); check_addr("t1_c1", 12'h001); expect_out("t1_c1", 1'b0, 12'h000, 32'h0);
      tick(); check_addr("t1_c2", 12'h002); expect_out("t1_c2", 1'b1, 12'h000, 32'd100);
      tick(); expect_out("t1_c3", 1'b1, 12'h001, 32'd101);
      tick(); expect_out("t1_c4", 1'b1, 12'h002, 32'd102); check_addr("t1_c4", 12'h004);
      bus.decode_ready = 1'b0;
      tick(4); check_addr("t2_hold", 12'h004); expect_out("t2_stall", 1'b1, 12'h002, 32'd102);
      bus.decode_ready = 1'b1;
      tick(); expect_out("t2_r1", 1'b1, 12'h003, 32'd103);
      tick(); expect_out("t2_r2", 1'b1, 12'h004, 32'd104);
      bus.decode_ready = 1'b0;
      tick(2); check_addr("t3_full", 12'h006); expect_out("t3_full", 1'b1, 12'h004, 32'd104);
      bus.redirect = 1'b1;
      bus.redirect_pc = 12'h040;
      bus.decode_ready = 1'b1;
      tick(); expect_out("t3_n1", 1'b0, 12'h000, 32'h0); check_addr("t3_n1", 12'h040);
      bus.redirect = 1'b0;
      tick(); expect_out("t3_n2", 1'b0, 12'h000, 32'h0);
      tick(); expect_out("t3_n3", 1'b1, 12'h040, 32'hA4);
      tick(); expect_out("t3_n4", 1'b1, 12'h041, 32'hA5);
      bus.redirect = 1'b1;
      bus.redirect_pc = 12'h100;
      tick(); expect_out("t4_n1", 1'b0, 12'h000, 32'h0);
      bus.redirect = 1'b0;
      tick(); expect_out("t4_n2", 1'b0, 12'h000, 32'h0);
      tick(); expect_out("t4_n3", 1'b1, 12'h100, 32'h164); check_addr("t4_n3", 12'h102);
      bus.fetch_en = 1'b0;
      tick(); expect_out("fe_n1", 1'b1, 12'h101, 32'h165);
      tick(); expect_out("fe_n2", 1'b0, 12'h000, 32'h0); check_addr("fe_hold", 12'h102);
      bus.fetch_en = 1'b1;
      tick(2); expect_out("fe_resume", 1'b1, 12'h102, 32'h166);
      bus.redirect = 1'b1;
      bus.redirect_pc = 12'hFFE;
      tick();
      bus.redirect = 1'b0;
      tick(2); expect_out("t5_ffe", 1'b1, 12'hFFE, 32'h1062);
      tick(); expect_out("t5_fff", 1'b1, 12'hFFF, 32'h1063);
      tick(); expect_out("t5_000", 1'b1, 12'h000, 32'd100);
      tick(); expect_out("t5_001", 1'b1, 12'h001, 32'd101);
      for (int i = 0; i < 16; i++) begin
         bus.decode_ready = pat[i];
         tick();
      end
      bus.decode_ready = 1'b1;
      tick(3);
      #2 rst = 1'b1;
      #1 expect_out("t6_async", 1'b0, 12'h000, 32'h0); check_addr("t6_async", 12'h000);
      @(posedge clk);
      #1 rst = 1'b0;
      check_addr("t6_rel", 12'h000);
      tick(2); expect_out("t6_first", 1'b1, 12'h000, 32'd100);
      tick(); expect_out("t6_second", 1'b1, 12'h001, 32'd101);
      tick(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
